// File: rtl/sramlike_arbiter_pkg.sv
// Shared definitions for the sram-like i/d bus arbiter.
package sramlike_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam int         RUN_W   = 4;
   localparam logic [3:0] RUN_SAT = 4'd15;

endpackage

// File: rtl/sramlike_grant_logic.sv
// Combinational grant decision (fixed data priority with starvation guard,
// or round-robin) and the run counter value to load if the grant is taken.
module sramlike_grant_logic
   import sramlike_arbiter_pkg::*;
#(
   parameter int DATA_PRIO    = 1,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic             inst_req,
   input  logic             data_req,
   input  logic             last_grant,
   input  logic [RUN_W-1:0] run_cnt,
   output logic             grant_valid,
   output logic             grant_owner,
   output logic [RUN_W-1:0] run_cnt_next
);

   localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_DATA_RUN);

   // Pick the winning requester for this cycle.
   always_comb begin
      grant_valid = inst_req | data_req;
      grant_owner = OWNER_INST;
      if (DATA_PRIO != 0) begin
         // Data wins unless inst has waited through a full data run.
         if (data_req && !(inst_req && (run_cnt == MAX_RUN))) begin
            grant_owner = OWNER_DATA;
         end
      end else begin
         if (inst_req && data_req) begin
            grant_owner = ~last_grant;
         end else if (data_req) begin
            grant_owner = OWNER_DATA;
         end
      end
   end

   // Count consecutive data grants made while inst is kept waiting.
   always_comb begin
      run_cnt_next = '0;
      if ((grant_owner == OWNER_DATA) && inst_req) begin
         run_cnt_next = (run_cnt == RUN_SAT) ? RUN_SAT : run_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one sram-like downstream port between the inst and data miss
// ports; one transaction outstanding, responses routed to the owner.
module sramlike_arbiter
   import sramlike_arbiter_pkg::*;
#(
   parameter int DATA_PRIO    = 1,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok
);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic             cancel_q, cancel_d;

   logic             gnt_valid;
   logic             gnt_owner;
   logic [RUN_W-1:0] gnt_run_cnt;
   logic             sel_owner;
   logic             fwd_req;
   logic             owner_req;
   logic             grant_fire;
   logic             inst_accept;

   sramlike_grant_logic #(
      .DATA_PRIO    (DATA_PRIO),
      .MAX_DATA_RUN (MAX_DATA_RUN)
   ) u_grant (
      .inst_req     (inst_req),
      .data_req     (data_req),
      .last_grant   (last_grant_q),
      .run_cnt      (run_cnt_q),
      .grant_valid  (gnt_valid),
      .grant_owner  (gnt_owner),
      .run_cnt_next (gnt_run_cnt)
   );

   // Select which side drives the bus: fresh grant in IDLE, locked owner after.
   always_comb begin
      owner_req = (owner_q == OWNER_DATA) ? data_req : inst_req;
      sel_owner = owner_q;
      fwd_req   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            sel_owner = gnt_owner;
            fwd_req   = gnt_valid;
         end
         ST_ADDR: fwd_req = owner_req;
         default: fwd_req = 1'b0;
      endcase
      grant_fire  = (state_q == ST_IDLE) && gnt_valid;
      inst_accept = fwd_req && (sel_owner == OWNER_INST) && mem_addr_ok;
   end

   // State register; reset discards any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept moves to DATA, response returns to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d = mem_addr_ok ? ST_DATA : ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (!owner_req) begin
               state_d = ST_IDLE;
            end else if (mem_addr_ok) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (mem_data_ok) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: forward the selected request, route handshakes to the owner.
   always_comb begin
      mem_req      = fwd_req;
      mem_wr       = (sel_owner == OWNER_DATA) ? data_wr    : inst_wr;
      mem_size     = (sel_owner == OWNER_DATA) ? data_size  : inst_size;
      mem_addr     = (sel_owner == OWNER_DATA) ? data_addr  : inst_addr;
      mem_wdata    = (sel_owner == OWNER_DATA) ? data_wdata : inst_wdata;
      inst_addr_ok = fwd_req && (sel_owner == OWNER_INST) && mem_addr_ok;
      data_addr_ok = fwd_req && (sel_owner == OWNER_DATA) && mem_addr_ok;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
      inst_data_ok = (state_q == ST_DATA) && (owner_q == OWNER_INST) &&
                     mem_data_ok && !cancel_q;
      data_data_ok = (state_q == ST_DATA) && (owner_q == OWNER_DATA) &&
                     mem_data_ok;
   end

   // Grant bookkeeping and the flush-cancel flag, next values.
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      run_cnt_d    = run_cnt_q;
      cancel_d     = cancel_q;
      if (grant_fire) begin
         owner_d      = gnt_owner;
         last_grant_d = gnt_owner;
         run_cnt_d    = gnt_run_cnt;
      end
      if ((state_q == ST_DATA) && mem_data_ok) begin
         cancel_d = 1'b0;
      end else if (flush && (((state_q == ST_DATA) && (owner_q == OWNER_INST)) ||
                             inst_accept)) begin
         cancel_d = 1'b1;
      end
   end

   // Bookkeeping registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= OWNER_INST;
         last_grant_q <= OWNER_DATA;
         run_cnt_q    <= '0;
         cancel_q     <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         run_cnt_q    <= run_cnt_d;
         cancel_q     <= cancel_d;
      end
   end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: instance 0 uses data priority (run limit 4),
// instance 1 round-robin; both share stimulus and are checked every cycle.
module tb_sramlike_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] mem_rdata;
   logic        mem_addr_ok, mem_data_ok;

   logic [31:0] o_inst_rdata [2];
   logic [31:0] o_data_rdata [2];
   logic        o_inst_addr_ok [2];
   logic        o_inst_data_ok [2];
   logic        o_data_addr_ok [2];
   logic        o_data_data_ok [2];
   logic        o_mem_req [2];
   logic        o_mem_wr [2];
   logic [1:0]  o_mem_size [2];
   logic [31:0] o_mem_addr [2];
   logic [31:0] o_mem_wdata [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         sramlike_arbiter #(
            .DATA_PRIO    ((gi == 0) ? 1 : 0),
            .MAX_DATA_RUN (4)
         ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .inst_req     (inst_req),
            .inst_wr      (inst_wr),
            .inst_size    (inst_size),
            .inst_addr    (inst_addr),
            .inst_wdata   (inst_wdata),
            .inst_rdata   (o_inst_rdata[gi]),
            .inst_addr_ok (o_inst_addr_ok[gi]),
            .inst_data_ok (o_inst_data_ok[gi]),
            .data_req     (data_req),
            .data_wr      (data_wr),
            .data_size    (data_size),
            .data_addr    (data_addr),
            .data_wdata   (data_wdata),
            .data_rdata   (o_data_rdata[gi]),
            .data_addr_ok (o_data_addr_ok[gi]),
            .data_data_ok (o_data_data_ok[gi]),
            .mem_req      (o_mem_req[gi]),
            .mem_wr       (o_mem_wr[gi]),
            .mem_size     (o_mem_size[gi]),
            .mem_addr     (o_mem_addr[gi]),
            .mem_wdata    (o_mem_wdata[gi]),
            .mem_rdata    (mem_rdata),
            .mem_addr_ok  (mem_addr_ok),
            .mem_data_ok  (mem_data_ok)
         );
      end
   endgenerate

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: transaction phase (0 none, 1 awaiting accept,
   // 2 awaiting response), its owner (1 = data), arbitration history.
   int m_phase [2];
   bit m_own [2];
   bit m_last [2];
   int m_run [2];
   bit m_cancel [2];

   // Accepted-grant order observed on the DUT ports (1 = data).
   bit glog0 [$];
   bit glog1 [$];

   task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k]  = 0;
         m_own[k]    = 1'b0;
         m_last[k]   = 1'b1;
         m_run[k]    = 0;
         m_cancel[k] = 1'b0;
      end
      glog0.delete();
      glog1.delete();
   endtask

   // Predict this cycle's outputs for instance k, compare, then advance the model.
   task automatic model_cycle(input int k);
      bit prio = (k == 0);
      bit act  = 1'b0;
      bit side = m_own[k];
      bit e_iok, e_dok;
      if (m_phase[k] == 0) begin
         if (inst_req || data_req) begin
            act = 1'b1;
            if (inst_req && data_req)
               side = prio ? (m_run[k] != 4) : !m_last[k];
            else
               side = data_req;
         end
      end else if (m_phase[k] == 1) begin
         act = m_own[k] ? data_req : inst_req;
      end
      e_iok = (m_phase[k] == 2) && !m_own[k] && mem_data_ok && !m_cancel[k];
      e_dok = (m_phase[k] == 2) && m_own[k] && mem_data_ok;

      chk1("mem_req", k, o_mem_req[k], act);
      if (act) begin
         chk32("mem_addr", k, o_mem_addr[k], side ? data_addr : inst_addr);
         chk32("mem_wdata", k, o_mem_wdata[k], side ? data_wdata : inst_wdata);
         chk1("mem_wr", k, o_mem_wr[k], side ? data_wr : inst_wr);
         chk32("mem_size", k, {30'b0, o_mem_size[k]}, {30'b0, side ? data_size : inst_size});
      end
      chk1("inst_addr_ok", k, o_inst_addr_ok[k], act && !side && mem_addr_ok);
      chk1("data_addr_ok", k, o_data_addr_ok[k], act && side && mem_addr_ok);
      chk1("inst_data_ok", k, o_inst_data_ok[k], e_iok);
      chk1("data_data_ok", k, o_data_data_ok[k], e_dok);
      chk32("inst_rdata", k, o_inst_rdata[k], mem_rdata);
      chk32("data_rdata", k, o_data_rdata[k], mem_rdata);

      if (o_inst_addr_ok[k] === 1'b1) begin
         if (k == 0) glog0.push_back(1'b0); else glog1.push_back(1'b0);
      end
      if (o_data_addr_ok[k] === 1'b1) begin
         if (k == 0) glog0.push_back(1'b1); else glog1.push_back(1'b1);
      end

      case (m_phase[k])
         0: if (act) begin
               m_own[k]  = side;
               m_last[k] = side;
               if (side && inst_req) m_run[k] = (m_run[k] < 15) ? m_run[k] + 1 : 15;
               else m_run[k] = 0;
               if (flush && !side && mem_addr_ok) m_cancel[k] = 1'b1;
               m_phase[k] = mem_addr_ok ? 2 : 1;
            end
         1: if (!act) m_phase[k] = 0;
            else if (mem_addr_ok) begin
               m_phase[k] = 2;
               if (flush && !m_own[k]) m_cancel[k] = 1'b1;
            end
         default: if (mem_data_ok) begin
               m_phase[k]  = 0;
               m_cancel[k] = 1'b0;
            end else if (flush && !m_own[k]) m_cancel[k] = 1'b1;
      endcase
   endtask

   task automatic sample();
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   task automatic idle_inputs();
      flush = 0; inst_req = 0; inst_wr = 0; inst_size = 2'd2;
      inst_addr = 32'h0; inst_wdata = 32'h0;
      data_req = 0; data_wr = 0; data_size = 2'd2;
      data_addr = 32'h0; data_wdata = 32'h0;
      mem_rdata = 32'h0; mem_addr_ok = 0; mem_data_ok = 0;
   endtask

   // Assert reset mid-cycle and check that outputs drop at once.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      for (int k = 0; k < 2; k++) begin
         chk1("rst_mem_req", k, o_mem_req[k], 1'b0);
         chk1("rst_inst_aok", k, o_inst_addr_ok[k], 1'b0);
         chk1("rst_data_aok", k, o_data_addr_ok[k], 1'b0);
         chk1("rst_inst_dok", k, o_inst_data_ok[k], 1'b0);
         chk1("rst_data_dok", k, o_data_data_ok[k], 1'b0);
      end
      model_reset();
      adv();
      rst = 1'b0;
   endtask

   bit exp_prio [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   bit exp_rr [4]    = '{0, 1, 0, 1};

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      do_reset();

      // Inst-only transaction.
      inst_req = 1; inst_addr = 32'hBFC00000;
      sample(); chk32("t1_addr_c0", 0, o_mem_addr[0], 32'hBFC00000); adv();
      tick();
      mem_addr_ok = 1;
      sample();
      chk1("t1_iaok_c2", 0, o_inst_addr_ok[0], 1'b1);
      chk1("t1_daok_c2", 0, o_data_addr_ok[0], 1'b0);
      adv();
      inst_req = 0; mem_addr_ok = 0;
      tick();
      mem_data_ok = 1; mem_rdata = 32'h3C080001;
      sample();
      chk1("t1_idok_c4", 0, o_inst_data_ok[0], 1'b1);
      chk32("t1_rdata_c4", 0, o_inst_rdata[0], 32'h3C080001);
      chk1("t1_ddok_c4", 0, o_data_data_ok[0], 1'b0);
      adv();
      mem_data_ok = 0;
      tick();

      // Simultaneous requests: data wins under fixed priority.
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC00100;
      data_req = 1; data_addr = 32'h80001000; mem_addr_ok = 1;
      sample();
      chk32("t2_addr_data", 0, o_mem_addr[0], 32'h80001000);
      chk1("t2_iaok_0", 0, o_inst_addr_ok[0], 1'b0);
      adv();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
      sample();
      chk1("t2_ddok", 0, o_data_data_ok[0], 1'b1);
      chk1("t2_iaok_1", 0, o_inst_addr_ok[0], 1'b0);
      adv();
      mem_data_ok = 0; mem_addr_ok = 1;
      sample();
      chk32("t2_addr_inst", 0, o_mem_addr[0], 32'hBFC00100);
      chk1("t2_iaok_2", 0, o_inst_addr_ok[0], 1'b1);
      adv();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      tick();
      mem_data_ok = 0;
      tick();

      // Continuous contention: starvation guard and round-robin order.
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC00200;
      data_req = 1; data_addr = 32'h80002000;
      mem_addr_ok = 1; mem_data_ok = 1;
      for (int c = 0; c < 20; c++) tick();
      idle_inputs();
      tick();
      chk32("t3_prio_len", 0, 32'(glog0.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < glog0.size()) chk1("t3_prio_seq", 0, glog0[i], exp_prio[i]);
      for (int i = 0; i < 4; i++)
         if (i < glog1.size()) chk1("t3_rr_seq", 1, glog1[i], exp_rr[i]);
      chk1("t3_rr_len", 1, glog1.size() >= 4, 1'b1);

      // Flush before the inst response cancels it; next inst is normal.
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC00300; mem_addr_ok = 1;
      tick();
      inst_req = 0; mem_addr_ok = 0;
      tick();
      flush = 1;
      tick();
      flush = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
      sample();
      chk1("t4_cancel", 0, o_inst_data_ok[0], 1'b0);
      chk1("t4_cancel", 1, o_inst_data_ok[1], 1'b0);
      adv();
      mem_data_ok = 0;
      tick();
      inst_req = 1; inst_addr = 32'hBFC00304; mem_addr_ok = 1;
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
      sample();
      chk1("t4_next_dok", 0, o_inst_data_ok[0], 1'b1);
      adv();
      mem_data_ok = 0;
      tick();

      // Reset while an inst transaction waits for data; stray response ignored.
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC00400; mem_addr_ok = 1;
      tick();
      inst_req = 0; mem_addr_ok = 0;
      tick();
      do_reset();
      mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
      sample();
      chk1("t5_stray_idok", 0, o_inst_data_ok[0], 1'b0);
      chk1("t5_stray_ddok", 0, o_data_data_ok[0], 1'b0);
      adv();
      mem_data_ok = 0;
      tick();

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         inst_req    = ($urandom_range(3) != 0);
         data_req    = ($urandom_range(2) != 0);
         inst_wr     = 1'b0;
         data_wr     = $urandom_range(1);
         inst_size   = 2'($urandom_range(3));
         data_size   = 2'($urandom_range(3));
         inst_addr   = $urandom;
         data_addr   = $urandom;
         inst_wdata  = $urandom;
         data_wdata  = $urandom;
         mem_rdata   = $urandom;
         mem_addr_ok = ($urandom_range(1) != 0);
         mem_data_ok = ($urandom_range(4) < 2);
         flush       = ($urandom_range(9) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
